// File: rtl/cpu_arith_pkg.sv
// Shared arithmetic definitions for the add/subtract datapath and its users.
// Holds the flag bundle, op-select encodings and saturation bounds.
package cpu_arith_pkg;

    localparam int MAX_W = 64;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic zero;
        logic neg;
        logic ovf;
        logic carry;
        logic lt;
    } flags_t;

    // Bounds are built in a MAX_W-bit container; callers keep the low width bits.
    function automatic logic [MAX_W-1:0] sat_max(input int width);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int width);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == width - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/subtract with optional signed saturation and flags.
// Shared by the pipelined ALU path and the divider step.
module addsub_core
    import cpu_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_opSub,
    input  logic             i_sat,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output flags_t           o_flags
);

    localparam logic [MAX_W-1:0] SAT_MAX_FULL = sat_max(WIDTH);
    localparam logic [MAX_W-1:0] SAT_MIN_FULL = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX = SAT_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN = SAT_MIN_FULL[WIDTH-1:0];

    logic             w_isSub;
    logic [WIDTH-1:0] w_bEff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_raw;
    logic             w_ovf;
    logic             w_carryOut;

    // Subtraction is a + ~b + 1, so the carry-in doubles as the op select.
    assign w_isSub    = (i_opSub == OP_SUB);
    assign w_bEff     = w_isSub ? ~i_b : i_b;
    assign w_sum      = {1'b0, i_a} + {1'b0, w_bEff} + {{WIDTH{1'b0}}, w_isSub};
    assign w_raw      = w_sum[WIDTH-1:0];
    assign w_carryOut = w_sum[WIDTH];
    assign w_ovf      = (i_a[WIDTH-1] == w_bEff[WIDTH-1]) && (w_raw[WIDTH-1] != i_a[WIDTH-1]);

    assign o_result = (i_sat && w_ovf) ? (i_a[WIDTH-1] ? SAT_MIN : SAT_MAX) : w_raw;

    always_comb begin
        o_flags       = '0;
        o_flags.zero  = (o_result == '0);
        o_flags.neg   = o_result[WIDTH-1];
        o_flags.ovf   = w_ovf;
        o_flags.carry = w_isSub ? ~w_carryOut : w_carryOut;
        o_flags.lt    = w_isSub & (w_raw[WIDTH-1] ^ w_ovf);
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with valid/ready on both sides and tag passthrough.
// Arithmetic is done at entry; later stages only delay and collapse bubbles.
module addsub_pipe
    import cpu_arith_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             sat,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             carry,
    output logic             lt
);

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_result [STAGES];
    logic [TAG_W-1:0]  r_tag    [STAGES];
    flags_t            r_flags  [STAGES];

    logic [STAGES-1:0] w_load;
    logic [WIDTH-1:0]  w_coreResult;
    flags_t            w_coreFlags;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .i_opSub  (op_sub),
        .i_sat    (sat),
        .i_a      (data1),
        .i_b      (data2),
        .o_result (w_coreResult),
        .o_flags  (w_coreFlags)
    );

    // A stage can load unless it and every stage after it are full while the output stalls.
    always_comb begin
        logic full;
        full   = 1'b1;
        w_load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full      = full & r_valid[k];
            w_load[k] = out_ready | ~full;
        end
    end

    assign in_ready = w_load[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            if (w_load[0]) r_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k]) r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Payload moves only with a valid op, so a stalled output holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_result[k] <= '0;
                r_tag[k]    <= '0;
                r_flags[k]  <= '0;
            end
        end else begin
            if (w_load[0] && in_valid) begin
                r_result[0] <= w_coreResult;
                r_tag[0]    <= tag_in;
                r_flags[0]  <= w_coreFlags;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k] && r_valid[k-1]) begin
                    r_result[k] <= r_result[k-1];
                    r_tag[k]    <= r_tag[k-1];
                    r_flags[k]  <= r_flags[k-1];
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign result    = r_result[STAGES-1];
    assign tag_out   = r_tag[STAGES-1];
    assign zero      = r_flags[STAGES-1].zero;
    assign neg       = r_flags[STAGES-1].neg;
    assign ovf       = r_flags[STAGES-1].ovf;
    assign carry     = r_flags[STAGES-1].carry;
    assign lt        = r_flags[STAGES-1].lt;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: default 32-bit/2-stage instance plus
// 8-bit single-stage and 8-bit four-stage instances for latency corners.
module tb_addsub_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic        opSub;
    logic        sat;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [4:0]  tagIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic [4:0]  tagOut;
    logic        zero, neg, ovf, carry, lt;

    logic        s1InValid, s1InReady, s1OpSub, s1OutValid;
    logic [7:0]  s1Data1, s1Data2, s1Result;
    logic [4:0]  s1TagIn, s1TagOut;
    logic        s1Zero, s1Neg, s1Ovf, s1Carry, s1Lt;

    logic        q4InValid, q4InReady, q4OpSub, q4OutValid;
    logic [7:0]  q4Data1, q4Data2, q4Result;
    logic [4:0]  q4TagIn, q4TagOut;
    logic        q4Zero, q4Neg, q4Ovf, q4Carry, q4Lt;

    int errors = 0;
    int checks = 0;

    addsub_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(inValid), .in_ready(inReady),
        .op_sub(opSub), .sat(sat), .data1(data1), .data2(data2), .tag_in(tagIn),
        .out_valid(outValid), .out_ready(outReady),
        .result(result), .tag_out(tagOut),
        .zero(zero), .neg(neg), .ovf(ovf), .carry(carry), .lt(lt)
    );

    addsub_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(s1InValid), .in_ready(s1InReady),
        .op_sub(s1OpSub), .sat(1'b0), .data1(s1Data1), .data2(s1Data2), .tag_in(s1TagIn),
        .out_valid(s1OutValid), .out_ready(1'b1),
        .result(s1Result), .tag_out(s1TagOut),
        .zero(s1Zero), .neg(s1Neg), .ovf(s1Ovf), .carry(s1Carry), .lt(s1Lt)
    );

    addsub_pipe #(.WIDTH(8), .STAGES(4), .TAG_W(5)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(q4InValid), .in_ready(q4InReady),
        .op_sub(q4OpSub), .sat(1'b0), .data1(q4Data1), .data2(q4Data2), .tag_in(q4TagIn),
        .out_valid(q4OutValid), .out_ready(1'b1),
        .result(q4Result), .tag_out(q4TagOut),
        .zero(q4Zero), .neg(q4Neg), .ovf(q4Ovf), .carry(q4Carry), .lt(q4Lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Presents one op for a single cycle; returns 1 time unit after the accepting edge.
    task automatic issue(input logic s, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t);
        inValid = 1'b1;
        opSub   = s;
        sat     = st;
        data1   = a;
        data2   = b;
        tagIn   = t;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; opSub = 1'b0; sat = 1'b0;
        data1 = '0; data2 = '0; tagIn = '0; outReady = 1'b1;
        s1InValid = 1'b0; s1OpSub = 1'b0; s1Data1 = '0; s1Data2 = '0; s1TagIn = '0;
        q4InValid = 1'b0; q4OpSub = 1'b0; q4Data1 = '0; q4Data2 = '0; q4TagIn = '0;
        #12;
        checks++;
        if (outValid !== 1'b0)
            $display("[TB] FAIL reset_out_valid got=%b exp=0", outValid);
        if (outValid !== 1'b0) errors++;
        checks++;
        if ({result, zero, neg, ovf, carry, lt, tagOut} !== 42'h0) begin
            $display("[TB] FAIL reset_payload got=%h exp=0", {result, zero, neg, ovf, carry, lt, tagOut});
            errors++;
        end
        checks++;
        if (inReady !== 1'b1) begin
            $display("[TB] FAIL reset_in_ready got=%b exp=1", inReady);
            errors++;
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_basic_sub;
        issue(1'b1, 1'b0, 32'd5, 32'd7, 5'd3);
        checks++;
        if (outValid !== 1'b0) begin
            $display("[TB] FAIL sub_early_valid got=%b exp=0", outValid);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if ({outValid, result, zero, neg, ovf, carry, lt, tagOut} !==
            {1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3}) begin
            $display("[TB] FAIL sub_5_7 got=%h exp=%h",
                     {outValid, result, zero, neg, ovf, carry, lt, tagOut},
                     {1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3});
            errors++;
        end
    endtask

    typedef struct {
        logic        s;
        logic        st;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [4:0]  f;
    } vec_t;

    task automatic test_saturation;
        vec_t v[4];
        // flag order: zero, neg, ovf, carry, lt
        v[0] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'b01100};
        v[1] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'h1, 32'h7FFFFFFF, 5'b00100};
        v[2] = '{1'b1, 1'b1, 32'h80000000, 32'h1, 32'h80000000, 5'b01101};
        v[3] = '{1'b1, 1'b0, 32'd9,        32'd9, 32'h0,        5'b10000};
        for (int i = 0; i < 4; i++) begin
            issue(v[i].s, v[i].st, v[i].a, v[i].b, 5'(i + 10));
            @(posedge clk);
            #1;
            checks++;
            if ({outValid, result, zero, neg, ovf, carry, lt, tagOut} !==
                {1'b1, v[i].r, v[i].f, 5'(i + 10)}) begin
                $display("[TB] FAIL sat_vec%0d got=%h exp=%h", i,
                         {outValid, result, zero, neg, ovf, carry, lt, tagOut},
                         {1'b1, v[i].r, v[i].f, 5'(i + 10)});
                errors++;
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        int nextTag = 0;
        int done = 0;
        logic expReady, acc, del;
        for (int cyc = 0; cyc < 40 && done < 6; cyc++) begin
            inValid  = (nextTag < 6);
            opSub    = 1'b0;
            sat      = 1'b0;
            data1    = 32'(nextTag);
            data2    = 32'd100;
            tagIn    = 5'(nextTag);
            outReady = !(cyc >= 3 && cyc <= 6);
            #1;
            expReady = outReady || ((nextTag - done) < 2);
            checks++;
            if (inReady !== expReady) begin
                $display("[TB] FAIL bp_in_ready cyc%0d got=%b exp=%b", cyc, inReady, expReady);
                errors++;
            end
            if (outValid === 1'b1) begin
                checks++;
                if ({result, tagOut} !== {32'(done + 100), 5'(done)}) begin
                    $display("[TB] FAIL bp_order cyc%0d got=%h exp=%h", cyc,
                             {result, tagOut}, {32'(done + 100), 5'(done)});
                    errors++;
                end
            end
            acc = inValid && inReady;
            del = outValid && outReady;
            @(posedge clk);
            #1;
            nextTag += int'(acc);
            done    += int'(del);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checks++;
        if (done !== 6 || nextTag !== 6) begin
            $display("[TB] FAIL bp_count got=%0d/%0d exp=6/6", done, nextTag);
            errors++;
        end
        idle(2);
    endtask

    task automatic test_flush;
        outReady = 1'b1;
        issue(1'b0, 1'b0, 32'd1, 32'd1, 5'd1);
        issue(1'b0, 1'b0, 32'd2, 32'd2, 5'd2);
        checks++;
        if ({outValid, tagOut, inReady} !== {1'b1, 5'd1, 1'b1}) begin
            $display("[TB] FAIL flush_setup got=%h exp=%h", {outValid, tagOut, inReady}, {1'b1, 5'd1, 1'b1});
            errors++;
        end
        flush = 1'b1;
        issue(1'b0, 1'b0, 32'd3, 32'd3, 5'd3);
        flush = 1'b0;
        checks++;
        if (outValid !== 1'b0) begin
            $display("[TB] FAIL flush_clear got=%b exp=0", outValid);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (outValid !== 1'b0) begin
            $display("[TB] FAIL flush_discard got=%b exp=0", outValid);
            errors++;
        end
        issue(1'b1, 1'b0, 32'd20, 32'd5, 5'd9);
        checks++;
        if (outValid !== 1'b0) begin
            $display("[TB] FAIL flush_post_early got=%b exp=0", outValid);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if ({outValid, result, zero, neg, ovf, carry, lt, tagOut} !==
            {1'b1, 32'd15, 5'b00000, 5'd9}) begin
            $display("[TB] FAIL flush_post_op got=%h exp=%h",
                     {outValid, result, zero, neg, ovf, carry, lt, tagOut}, {1'b1, 32'd15, 5'b00000, 5'd9});
            errors++;
        end
        idle(2);
    endtask

    task automatic test_async_reset;
        outReady = 1'b0;
        issue(1'b0, 1'b0, 32'd4, 32'd4, 5'd7);
        @(posedge clk);
        #1;
        checks++;
        if ({outValid, result, tagOut} !== {1'b1, 32'd8, 5'd7}) begin
            $display("[TB] FAIL ar_held got=%h exp=%h", {outValid, result, tagOut}, {1'b1, 32'd8, 5'd7});
            errors++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({outValid, result, zero, neg, ovf, carry, lt, tagOut} !== 43'h0) begin
            $display("[TB] FAIL ar_clear got=%h exp=0", {outValid, result, zero, neg, ovf, carry, lt, tagOut});
            errors++;
        end
        #2;
        rst_n    = 1'b1;
        outReady = 1'b1;
        #1;
        issue(1'b0, 1'b0, 32'd1, 32'd2, 5'd4);
        @(posedge clk);
        #1;
        checks++;
        if ({outValid, result, zero, neg, ovf, carry, lt, tagOut} !==
            {1'b1, 32'd3, 5'b00000, 5'd4}) begin
            $display("[TB] FAIL ar_post_op got=%h exp=%h",
                     {outValid, result, zero, neg, ovf, carry, lt, tagOut}, {1'b1, 32'd3, 5'b00000, 5'd4});
            errors++;
        end
        idle(2);
    endtask

    task automatic test_small_widths;
        checks++;
        if ({s1InReady, q4InReady} !== 2'b11) begin
            $display("[TB] FAIL small_ready got=%b exp=11", {s1InReady, q4InReady});
            errors++;
        end
        s1InValid = 1'b1; s1OpSub = 1'b1; s1Data1 = 8'h80; s1Data2 = 8'h01; s1TagIn = 5'd2;
        @(posedge clk);
        #1;
        s1InValid = 1'b0;
        checks++;
        if ({s1OutValid, s1Result, s1Zero, s1Neg, s1Ovf, s1Carry, s1Lt, s1TagOut} !==
            {1'b1, 8'h7F, 5'b00101, 5'd2}) begin
            $display("[TB] FAIL s1_sub got=%h exp=%h",
                     {s1OutValid, s1Result, s1Zero, s1Neg, s1Ovf, s1Carry, s1Lt, s1TagOut},
                     {1'b1, 8'h7F, 5'b00101, 5'd2});
            errors++;
        end
        q4InValid = 1'b1; q4OpSub = 1'b0; q4Data1 = 8'hFF; q4Data2 = 8'h01; q4TagIn = 5'd5;
        @(posedge clk);
        #1;
        q4InValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q4OutValid !== 1'b0) begin
            $display("[TB] FAIL q4_early got=%b exp=0", q4OutValid);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if ({q4OutValid, q4Result, q4Zero, q4Neg, q4Ovf, q4Carry, q4Lt, q4TagOut} !==
            {1'b1, 8'h00, 5'b10010, 5'd5}) begin
            $display("[TB] FAIL q4_add got=%h exp=%h",
                     {q4OutValid, q4Result, q4Zero, q4Neg, q4Ovf, q4Carry, q4Lt, q4TagOut},
                     {1'b1, 8'h00, 5'b10010, 5'd5});
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_sub();
        test_saturation();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_small_widths();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
